// File: rtl/id_pipe_ctrl.sv
// ID-stage pipeline controller: carries the decoded control bundle through
// EX/MEM/WB, detects load-use hazards, drives EX forwarding selects,
// squashes issue behind a pending exception and flushes IF on jumps.
module id_pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Valid,
  input  logic [4:0]       Rs,
  input  logic [4:0]       Rt,
  input  logic             UsesRt,
  input  logic [4:0]       Dst,
  input  logic             RegWr,
  input  logic             MemWr,
  input  logic             MemtoReg,
  input  logic [1:0]       LoadType,
  input  logic             Jump,
  input  logic             Exception,
  input  logic             Exc_ack,
  output logic             Stall,
  output logic             Flush_IF,
  output logic             ExcPending,
  output logic             ex_RegWr,
  output logic             ex_MemWr,
  output logic             ex_MemtoReg,
  output logic [1:0]       ex_LoadType,
  output logic [4:0]       ex_Dst,
  output logic [1:0]       Fwd_A,
  output logic [1:0]       Fwd_B,
  output logic             mem_RegWr,
  output logic             mem_MemWr,
  output logic             mem_MemtoReg,
  output logic [1:0]       mem_LoadType,
  output logic [4:0]       mem_Dst,
  output logic             wb_RegWr,
  output logic             wb_MemtoReg,
  output logic [4:0]       wb_Dst,
  output logic [CNT_W-1:0] Retired
);

  localparam int STAGES = 3;  // EX=1, MEM=2, WB=3

  typedef struct packed {
    logic       reg_wr;
    logic       mem_wr;
    logic       mem_to_reg;
    logic [1:0] load_type;
    logic [4:0] dst;
  } ctl_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  logic [STAGES:1]   vld_pipe;
  ctl_t              id_ctl, ex_ctl, mem_ctl, wb_ctl;
  logic [4:0]        ex_rs, ex_rt;
  logic              ex_uses_rt;
  logic              exc_pending;
  logic              bubble;
  logic [CNT_W-1:0]  retired;

  // Pick the youngest producer of src; register 0 is never a source.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic en,
                                         input logic mv, input ctl_t mc,
                                         input logic wv, input ctl_t wc);
    logic [1:0] sel;
    sel = FWD_RF;
    if (en) begin
      if (mv && mc.reg_wr && mc.dst != 5'd0 && mc.dst == src)
        sel = FWD_MEM;
      else if (wv && wc.reg_wr && wc.dst != 5'd0 && wc.dst == src)
        sel = FWD_WB;
    end
    return sel;
  endfunction

  // Hazard, bubble, flush and the ID bundle to launch into EX.
  always_comb begin
    id_ctl           = '0;
    id_ctl.reg_wr    = RegWr;
    id_ctl.mem_wr    = MemWr;
    id_ctl.mem_to_reg = MemtoReg;
    id_ctl.load_type = LoadType;
    id_ctl.dst       = Dst;
    // Load in EX whose result the ID instruction needs: hold one cycle so
    // the load has reached a forwardable stage when the consumer enters EX.
    Stall = Valid && vld_pipe[1] && ex_ctl.mem_to_reg && ex_ctl.reg_wr &&
            ex_ctl.dst != 5'd0 &&
            (ex_ctl.dst == Rs || (UsesRt && ex_ctl.dst == Rt));
    bubble   = Stall || !Valid || exc_pending || (Valid && Exception);
    Flush_IF = Valid && Jump && !Stall && !exc_pending && !Exception;
  end

  // Stage registers: MEM and WB always advance; only ID->EX honours bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      ex_ctl     <= '0;
      mem_ctl    <= '0;
      wb_ctl     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_uses_rt <= 1'b0;
    end else begin
      vld_pipe[STAGES:2] <= vld_pipe[STAGES-1:1];
      mem_ctl <= ex_ctl;
      wb_ctl  <= mem_ctl;
      if (bubble) begin
        vld_pipe[1] <= 1'b0;
        ex_ctl      <= '0;
        ex_rs       <= '0;
        ex_rt       <= '0;
        ex_uses_rt  <= 1'b0;
      end else begin
        vld_pipe[1] <= 1'b1;
        ex_ctl      <= id_ctl;
        ex_rs       <= Rs;
        ex_rt       <= Rt;
        ex_uses_rt  <= UsesRt;
      end
    end
  end

  // Pending exception: ack wins over a same-cycle fault; ack while idle is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      exc_pending <= 1'b0;
    else if (exc_pending && Exc_ack)
      exc_pending <= 1'b0;
    else if (Valid && Exception && !Stall && !exc_pending)
      exc_pending <= 1'b1;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retired <= '0;
    else if (vld_pipe[STAGES])
      retired <= retired + CNT_W'(1);
  end

  assign Fwd_A = fwd_sel(ex_rs, vld_pipe[1], vld_pipe[2], mem_ctl, vld_pipe[3], wb_ctl);
  assign Fwd_B = fwd_sel(ex_rt, vld_pipe[1] && ex_uses_rt, vld_pipe[2], mem_ctl,
                         vld_pipe[3], wb_ctl);

  assign ExcPending   = exc_pending;
  assign ex_RegWr     = ex_ctl.reg_wr;
  assign ex_MemWr     = ex_ctl.mem_wr;
  assign ex_MemtoReg  = ex_ctl.mem_to_reg;
  assign ex_LoadType  = ex_ctl.load_type;
  assign ex_Dst       = ex_ctl.dst;
  assign mem_RegWr    = mem_ctl.reg_wr;
  assign mem_MemWr    = mem_ctl.mem_wr;
  assign mem_MemtoReg = mem_ctl.mem_to_reg;
  assign mem_LoadType = mem_ctl.load_type;
  assign mem_Dst      = mem_ctl.dst;
  assign wb_RegWr     = wb_ctl.reg_wr;
  assign wb_MemtoReg  = wb_ctl.mem_to_reg;
  assign wb_Dst       = wb_ctl.dst;
  assign Retired      = retired;

endmodule

// File: tb/tb_id_pipe_ctrl.sv
// Directed bench for id_pipe_ctrl; a second instance with a 2-bit counter
// shares all inputs to exercise counter wrap.
module tb_id_pipe_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic Valid = 0, UsesRt = 0, RegWr = 0, MemWr = 0, MemtoReg = 0;
  logic Jump = 0, Exception = 0, Exc_ack = 0;
  logic [4:0] Rs = 0, Rt = 0, Dst = 0;
  logic [1:0] LoadType = 0;

  logic Stall, Flush_IF, ExcPending, ex_RegWr, ex_MemWr, ex_MemtoReg;
  logic [1:0] ex_LoadType, Fwd_A, Fwd_B, mem_LoadType;
  logic [4:0] ex_Dst, mem_Dst, wb_Dst;
  logic mem_RegWr, mem_MemWr, mem_MemtoReg, wb_RegWr, wb_MemtoReg;
  logic [15:0] Retired;

  logic d2_Stall, d2_Flush_IF, d2_ExcPending, d2_ex_RegWr, d2_ex_MemWr, d2_ex_MemtoReg;
  logic [1:0] d2_ex_LoadType, d2_Fwd_A, d2_Fwd_B, d2_mem_LoadType;
  logic [4:0] d2_ex_Dst, d2_mem_Dst, d2_wb_Dst;
  logic d2_mem_RegWr, d2_mem_MemWr, d2_mem_MemtoReg, d2_wb_RegWr, d2_wb_MemtoReg;
  logic [1:0] d2_Retired;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  id_pipe_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .Valid(Valid), .Rs(Rs), .Rt(Rt), .UsesRt(UsesRt),
    .Dst(Dst), .RegWr(RegWr), .MemWr(MemWr), .MemtoReg(MemtoReg), .LoadType(LoadType),
    .Jump(Jump), .Exception(Exception), .Exc_ack(Exc_ack), .Stall(Stall),
    .Flush_IF(Flush_IF), .ExcPending(ExcPending), .ex_RegWr(ex_RegWr),
    .ex_MemWr(ex_MemWr), .ex_MemtoReg(ex_MemtoReg), .ex_LoadType(ex_LoadType),
    .ex_Dst(ex_Dst), .Fwd_A(Fwd_A), .Fwd_B(Fwd_B), .mem_RegWr(mem_RegWr),
    .mem_MemWr(mem_MemWr), .mem_MemtoReg(mem_MemtoReg), .mem_LoadType(mem_LoadType),
    .mem_Dst(mem_Dst), .wb_RegWr(wb_RegWr), .wb_MemtoReg(wb_MemtoReg),
    .wb_Dst(wb_Dst), .Retired(Retired));

  id_pipe_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .Valid(Valid), .Rs(Rs), .Rt(Rt), .UsesRt(UsesRt),
    .Dst(Dst), .RegWr(RegWr), .MemWr(MemWr), .MemtoReg(MemtoReg), .LoadType(LoadType),
    .Jump(Jump), .Exception(Exception), .Exc_ack(Exc_ack), .Stall(d2_Stall),
    .Flush_IF(d2_Flush_IF), .ExcPending(d2_ExcPending), .ex_RegWr(d2_ex_RegWr),
    .ex_MemWr(d2_ex_MemWr), .ex_MemtoReg(d2_ex_MemtoReg), .ex_LoadType(d2_ex_LoadType),
    .ex_Dst(d2_ex_Dst), .Fwd_A(d2_Fwd_A), .Fwd_B(d2_Fwd_B), .mem_RegWr(d2_mem_RegWr),
    .mem_MemWr(d2_mem_MemWr), .mem_MemtoReg(d2_mem_MemtoReg),
    .mem_LoadType(d2_mem_LoadType), .mem_Dst(d2_mem_Dst), .wb_RegWr(d2_wb_RegWr),
    .wb_MemtoReg(d2_wb_MemtoReg), .wb_Dst(d2_wb_Dst), .Retired(d2_Retired));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ut, input logic [4:0] dst, input logic rw,
                        input logic mw, input logic m2r, input logic [1:0] lt,
                        input logic j, input logic e);
    Valid = v; Rs = rs; Rt = rt; UsesRt = ut; Dst = dst; RegWr = rw;
    MemWr = mw; MemtoReg = m2r; LoadType = lt; Jump = j; Exception = e;
  endtask

  task automatic idle(input int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    #3;
    checks++; if (Retired !== 16'd0) begin failures++; $display("FAIL rst_retired got=%0d exp=0", Retired); end
    checks++; if (ExcPending !== 1'b0) begin failures++; $display("FAIL rst_excpend got=%0b exp=0", ExcPending); end
    checks++; if ({ex_RegWr, mem_RegWr, wb_RegWr} !== 3'b000) begin failures++; $display("FAIL rst_regwr got=%0b exp=000", {ex_RegWr, mem_RegWr, wb_RegWr}); end
    checks++; if ({Stall, Flush_IF, Fwd_A, Fwd_B} !== 6'd0) begin failures++; $display("FAIL rst_comb got=%0b exp=0", {Stall, Flush_IF, Fwd_A, Fwd_B}); end
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    idle(3);
    set_id(1, 5'd1, 5'd0, 0, 5'd5, 1, 0, 1, 2'd2, 0, 0);  // lw r5
    #1;
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL lu_nostall got=%0b exp=0", Stall); end
    tick();
    checks++; if ({ex_MemtoReg, ex_LoadType} !== 3'b110) begin failures++; $display("FAIL lu_ex_load got=%0b exp=110", {ex_MemtoReg, ex_LoadType}); end
    set_id(1, 5'd5, 5'd0, 0, 5'd6, 1, 0, 0, 2'd0, 0, 0);  // add uses r5
    #1;
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0b exp=1", Stall); end
    tick();
    checks++; if ({ex_RegWr, ex_Dst} !== 6'd0) begin failures++; $display("FAIL lu_bubble got=%0h exp=0", {ex_RegWr, ex_Dst}); end
    checks++; if ({mem_MemtoReg, mem_LoadType, mem_Dst} !== {1'b1, 2'd2, 5'd5}) begin failures++; $display("FAIL lu_mem got=%0h exp=%0h", {mem_MemtoReg, mem_LoadType, mem_Dst}, {1'b1, 2'd2, 5'd5}); end
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL lu_stall_once got=%0b exp=0", Stall); end
    tick();
    // The load has moved on to WB by the time the consumer sits in EX.
    checks++; if (ex_Dst !== 5'd6) begin failures++; $display("FAIL lu_ex_add got=%0d exp=6", ex_Dst); end
    checks++; if (Fwd_A !== 2'b10) begin failures++; $display("FAIL lu_fwd_a got=%0b exp=10", Fwd_A); end
    checks++; if ({wb_MemtoReg, wb_Dst} !== {1'b1, 5'd5}) begin failures++; $display("FAIL lu_wb got=%0h exp=%0h", {wb_MemtoReg, wb_Dst}, {1'b1, 5'd5}); end
  endtask

  task automatic test_forward();
    idle(3);
    set_id(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0, 2'd0, 0, 0);  // add r3
    tick();
    set_id(1, 5'd3, 5'd3, 1, 5'd4, 1, 0, 0, 2'd0, 0, 0);  // sub r3,r3
    #1;
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL fw_nostall got=%0b exp=0", Stall); end
    tick();
    set_id(1, 5'd3, 5'd3, 0, 5'd8, 1, 0, 0, 2'd0, 0, 0);  // rs=r3, rt unused
    #1;
    checks++; if ({Fwd_A, Fwd_B} !== 4'b0101) begin failures++; $display("FAIL fw_mem got=%0b exp=0101", {Fwd_A, Fwd_B}); end
    tick();
    checks++; if ({Fwd_A, Fwd_B} !== 4'b1000) begin failures++; $display("FAIL fw_wb got=%0b exp=1000", {Fwd_A, Fwd_B}); end
    checks++; if ({mem_Dst, wb_Dst} !== {5'd4, 5'd3}) begin failures++; $display("FAIL fw_dsts got=%0h exp=%0h", {mem_Dst, wb_Dst}, {5'd4, 5'd3}); end
    idle(3);
    set_id(1, 5'd1, 5'd0, 0, 5'd0, 1, 0, 1, 2'd0, 0, 0);  // lw r0
    tick();
    set_id(1, 5'd0, 5'd0, 1, 5'd7, 1, 0, 0, 2'd0, 0, 0);
    #1;
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL fw_r0_stall got=%0b exp=0", Stall); end
    tick();
    checks++; if ({Fwd_A, Fwd_B} !== 4'b0000) begin failures++; $display("FAIL fw_r0 got=%0b exp=0000", {Fwd_A, Fwd_B}); end
  endtask

  task automatic test_exception();
    idle(3);
    set_id(1, 5'd1, 5'd2, 1, 5'd9, 1, 1, 0, 2'd0, 0, 1);
    #1;
    checks++; if (ExcPending !== 1'b0) begin failures++; $display("FAIL ex_pre got=%0b exp=0", ExcPending); end
    tick();
    checks++; if (ExcPending !== 1'b1) begin failures++; $display("FAIL ex_set got=%0b exp=1", ExcPending); end
    checks++; if ({ex_RegWr, ex_MemWr} !== 2'b00) begin failures++; $display("FAIL ex_slot got=%0b exp=00", {ex_RegWr, ex_MemWr}); end
    set_id(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 2'd0, 1, 0);  // jump while pending
    #1;
    checks++; if (Flush_IF !== 1'b0) begin failures++; $display("FAIL ex_noflush got=%0b exp=0", Flush_IF); end
    set_id(1, 5'd2, 5'd3, 1, 5'd0, 0, 1, 0, 2'd0, 0, 0);  // sw
    tick();
    checks++; if (ex_MemWr !== 1'b0) begin failures++; $display("FAIL ex_sq_ex got=%0b exp=0", ex_MemWr); end
    tick();
    checks++; if ({mem_MemWr, ExcPending} !== 2'b01) begin failures++; $display("FAIL ex_sq_mem got=%0b exp=01", {mem_MemWr, ExcPending}); end
    Exc_ack = 1'b1;
    tick();
    Exc_ack = 1'b0;
    checks++; if ({ExcPending, ex_MemWr} !== 2'b00) begin failures++; $display("FAIL ex_ack got=%0b exp=00", {ExcPending, ex_MemWr}); end
    tick();
    checks++; if (ex_MemWr !== 1'b1) begin failures++; $display("FAIL ex_resume got=%0b exp=1", ex_MemWr); end
    tick();
    checks++; if (mem_MemWr !== 1'b1) begin failures++; $display("FAIL ex_resume_mem got=%0b exp=1", mem_MemWr); end
  endtask

  task automatic test_ack_collision();
    idle(2);
    set_id(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 2'd0, 0, 1);
    tick();
    checks++; if (ExcPending !== 1'b1) begin failures++; $display("FAIL col_set got=%0b exp=1", ExcPending); end
    Exc_ack = 1'b1;
    tick();
    Exc_ack = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (ExcPending !== 1'b0) begin failures++; $display("FAIL col_ack got=%0b exp=0", ExcPending); end
    tick();
    checks++; if (ExcPending !== 1'b0) begin failures++; $display("FAIL col_hold got=%0b exp=0", ExcPending); end
  endtask

  task automatic test_jump();
    idle(3);
    set_id(1, 5'd0, 5'd0, 0, 5'd31, 1, 0, 0, 2'd0, 1, 0);  // jal
    #1;
    checks++; if (Flush_IF !== 1'b1) begin failures++; $display("FAIL jp_flush got=%0b exp=1", Flush_IF); end
    tick();
    checks++; if ({ex_RegWr, ex_Dst} !== {1'b1, 5'd31}) begin failures++; $display("FAIL jp_ex got=%0h exp=%0h", {ex_RegWr, ex_Dst}, {1'b1, 5'd31}); end
    idle(2);
    set_id(1, 5'd1, 5'd0, 0, 5'd5, 1, 0, 1, 2'd0, 0, 0);  // lw r5
    tick();
    set_id(1, 5'd5, 5'd0, 0, 5'd0, 0, 0, 0, 2'd0, 1, 0);  // jr r5
    #1;
    checks++; if ({Stall, Flush_IF} !== 2'b10) begin failures++; $display("FAIL jp_stall got=%0b exp=10", {Stall, Flush_IF}); end
    set_id(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 2'd0, 1, 1);  // jump that faults
    #1;
    checks++; if (Flush_IF !== 1'b0) begin failures++; $display("FAIL jp_exc got=%0b exp=0", Flush_IF); end
    idle(3);
  endtask

  task automatic test_retired();
    set_id(1, 5'd1, 5'd0, 0, 5'd5, 1, 0, 1, 2'd0, 0, 0);  // lw r5
    tick();
    set_id(1, 5'd5, 5'd0, 0, 5'd6, 1, 0, 0, 2'd0, 0, 0);
    #1;
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL rt_prestall got=%0b exp=1", Stall); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL rt_async_stall got=%0b exp=0", Stall); end
    checks++; if ({ex_RegWr, ex_MemtoReg, ex_Dst} !== 7'd0) begin failures++; $display("FAIL rt_async_ex got=%0h exp=0", {ex_RegWr, ex_MemtoReg, ex_Dst}); end
    checks++; if ({mem_RegWr, mem_Dst, wb_RegWr, wb_Dst} !== 12'd0) begin failures++; $display("FAIL rt_async_mw got=%0h exp=0", {mem_RegWr, mem_Dst, wb_RegWr, wb_Dst}); end
    checks++; if ({Retired, d2_Retired} !== 18'd0) begin failures++; $display("FAIL rt_async_cnt got=%0h exp=0", {Retired, d2_Retired}); end
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    tick();
    for (int i = 1; i <= 3; i++) begin
      set_id(1, 5'd0, 5'd0, 0, 5'(i), 1, 0, 0, 2'd0, 0, 0);
      tick();
    end
    idle(5);
    checks++; if (Retired !== 16'd3) begin failures++; $display("FAIL rt_three got=%0d exp=3", Retired); end
    checks++; if (d2_Retired !== 2'd3) begin failures++; $display("FAIL rt_three_w2 got=%0d exp=3", d2_Retired); end
    for (int i = 4; i <= 5; i++) begin
      set_id(1, 5'd0, 5'd0, 0, 5'(i), 1, 0, 0, 2'd0, 0, 0);
      tick();
    end
    idle(5);
    checks++; if (Retired !== 16'd5) begin failures++; $display("FAIL rt_five got=%0d exp=5", Retired); end
    checks++; if (d2_Retired !== 2'd1) begin failures++; $display("FAIL rt_wrap got=%0d exp=1", d2_Retired); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_exception();
    test_ack_collision();
    test_jump();
    test_retired();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
